msx_mouse_port: RTL and testbench
=================================

// Module: msx_mouse_port
// PURPOSE
// - Converts host mouse packets and digital joystick state into the 6-pin level
//   pattern of MSX general-purpose port A. It sits directly upstream of the emsx
//   core's pJoyA/pStra pins; the top level turns port_o bits that are 1 into Z.
// - Mouse motion is accumulated with saturation between MSX reads and is then
//   served as four nibbles, sequenced by STR toggles per the MSX mouse protocol.
// - The block switches automatically between mouse mode and joystick mode.
// PARAMETERS
// - TIMEOUT    100000  clk_sys cycles with no STR edge before the nibble index returns to 0
// - INVERT_X   1       1: send -dx (MSX X is positive-left); 0: send dx unchanged
// PORTS
// - clk_sys       in   1  system clock (21.48 MHz); all logic is on its rising edge
// - reset         in   1  synchronous reset, active-high
// - mouse_x       in   9  signed X delta of one host packet (two's complement, bit8 = sign)
// - mouse_y       in   9  signed Y delta, positive = up
// - mouse_flags   in   8  [0] left button, [1] right button (active-high); other bits ignored
// - mouse_strobe  in   1  one-cycle pulse; mouse_x/y/flags are valid in the same cycle
// - joy           in   6  active-high [0]R [1]L [2]D [3]U [4]btnA [5]btnB
// - stra          in   1  STR pin level from the emsx core (PSG port B bit)
// - port_o        out  6  pin levels: 1 = released (Z), 0 = driven low; [3:0] data, [5:4] buttons
// - mouse_active  out  1  1 = mouse mode
// - nibble_idx    out  2  index of the next nibble to be served (debug/verification)
// BEHAVIOUR
// - Reset: port_o=6'h3F, mouse_active=0, nibble_idx=0; accumulators, snapshots and
//   timeout counter=0; the STR history register is loaded with the current stra.
// - Mode select, applied in priority order:
//   - reset;
//   - mouse_strobe sets mouse_active=1;
//   - otherwise, any joy bit at 1 clears mouse_active.
//   - A strobe and a joy press in the same cycle: the strobe wins.
// - Joystick mode: port_o = ~joy | {6{stra}}, registered (1-cycle latency).
//   Inputs are still accumulated in this mode, but the snapshot logic is not run.
// - Accumulation: on each mouse_strobe, acc_x += (INVERT_X ? -mouse_x : mouse_x)
//   and acc_y += mouse_y.
//   - Sums use 10-bit signed arithmetic, then saturate to [-128,+127]. Negating
//     -256 gives +256, which then saturates to +127.
// - STR edge: stra differs from its registered value. Only edges seen in mouse mode
//   advance the sequence. Nibble served per nibble_idx at each edge:
//   - 0: snap_x/snap_y <= acc, and acc <= acc - snap. Serve snap_x[7:4] from the
//     value being captured (no extra cycle).
//   - 1: snap_x[3:0].
//   - 2: snap_y[7:4].
//   - 3: snap_y[3:0].
//   - nibble_idx increments modulo 4; port_o[3:0] updates 1 cycle after the edge.
// - Simultaneous edge(idx 0) + strobe: acc <= sat(acc - snap + delta). No motion is lost.
// - Buttons: port_o[5:4] = ~mouse_flags[1:0], latched on every strobe, independent of STR.
// - Timeout: every STR edge loads the counter with TIMEOUT; otherwise it decrements
//   while non-zero. The transition 1->0 forces nibble_idx=0. Data already served stays valid.
// - Leaving mouse mode: nibble_idx=0, timeout=0, acc kept. Entering mouse mode:
//   port_o[3:0]=4'hF until the first edge.
// - Reset mid-sequence: immediate return to reset values; no partial nibble is held.
// TESTING
// - Strobe x=+5,y=+3; toggle stra 4x -> nibbles F,B,0,3 (x=-5 = 8'hFB); idx wraps to 0.
// - 3 strobes of x=-100 (INVERT_X=1) -> acc_x saturates at +127; served 7,F; next read 0,0.
// - Strobe x=+2 in the same cycle as the idx-0 edge with acc_x=-4 -> serves F,C; next read F,E.
// - 2 edges, then idle TIMEOUT+1 cycles -> nibble_idx=0; next edge serves X high nibble.
// - Mouse mode, joy=6'b000100 -> mouse_active=0 next cycle; stra=0 gives port_o=6'b111011;
//   stra=1 gives 3F.
// - flags=2'b01 strobe -> port_o[5:4]=2'b10; assert reset mid-sequence -> port_o=3F, idx=0.

Source files
------------

// File: rtl/msx_mouse_port.sv
// msx_mouse_port
//
// Drives the six pins of MSX general-purpose port A from either a host mouse
// or a digital joystick. The level pattern on port_o feeds the emsx core's
// pJoyA/pStra pins; the top level turns every port_o bit that is 1 into Z.
//
// Mouse motion from host packets is accumulated with saturation to an 8-bit
// signed range. The MSX reads it as four nibbles (X high, X low, Y high,
// Y low), advancing one nibble on every STR toggle. If STR stays quiet for
// TIMEOUT cycles, the sequence restarts at the X high nibble.
//
// Parameters:
//   TIMEOUT   - idle clk_sys cycles with no STR edge before the index restarts
//   INVERT_X  - 1: serve -dx (MSX X is positive-left); 0: serve dx unchanged
//
// Ports:
//   clk_sys       in   system clock, rising-edge logic
//   reset         in   synchronous reset, active-high
//   mouse_x       in   9-bit signed X delta of one host packet
//   mouse_y       in   9-bit signed Y delta, positive = up
//   mouse_flags   in   [0] left, [1] right button (active-high); rest ignored
//   mouse_strobe  in   one-cycle packet pulse
//   joy           in   active-high [0]R [1]L [2]D [3]U [4]A [5]B
//   stra          in   STR pin level from the core
//   port_o        out  pin levels, 1 = released, 0 = driven low
//   mouse_active  out  1 = mouse mode
//   nibble_idx    out  index of the next nibble to be served
//
// Handshake: mouse_strobe is a valid-only pulse. The port has no ready; a
// packet is always accepted in the cycle its strobe is high, and
// mouse_x/mouse_y/mouse_flags are only looked at in that cycle.

module msx_mouse_port #(
    parameter int TIMEOUT  = 100000,
    parameter bit INVERT_X = 1'b1
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [8:0] mouse_x,
    input  logic [8:0] mouse_y,
    input  logic [7:0] mouse_flags,
    input  logic       mouse_strobe,
    input  logic [5:0] joy,
    input  logic       stra,
    output logic [5:0] port_o,
    output logic       mouse_active,
    output logic [1:0] nibble_idx
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    typedef enum logic [1:0] {
        NIB_XH = 2'd0,
        NIB_XL = 2'd1,
        NIB_YH = 2'd2,
        NIB_YL = 2'd3
    } nib_t;

    nib_t             r_nib_state;
    nib_t             w_nib_next;

    logic             r_mouse_active;
    logic             r_stra_q;
    logic [5:0]       r_port;
    logic [7:0]       r_acc_x;
    logic [7:0]       r_acc_y;
    // The X high nibble is served straight from the accumulator at the
    // capture edge, so only the low half of the X snapshot is ever needed.
    logic [3:0]       r_snap_x_lo;
    logic [7:0]       r_snap_y;
    logic [TW-1:0]    r_tmo;

    logic             w_edge;
    logic             w_next_active;
    logic             w_adv;
    logic             w_snap;
    logic             w_tmo_expire;
    logic signed [9:0] w_mx;
    logic signed [9:0] w_dx;
    logic signed [9:0] w_dy;
    logic signed [9:0] w_base_x;
    logic signed [9:0] w_base_y;
    logic signed [9:0] w_sum_x;
    logic signed [9:0] w_sum_y;
    logic [3:0]       w_nibble;
    logic             w_unused_flags;

    assign w_unused_flags = ^mouse_flags[7:2];

    function automatic logic [7:0] sat8(input logic signed [9:0] v);
        if (v > 10'sd127) begin
            return 8'h7F;
        end else if (v < -10'sd128) begin
            return 8'h80;
        end else begin
            return v[7:0];
        end
    endfunction

    // Mode: a strobe always wins over a joystick press in the same cycle.
    assign w_next_active = mouse_strobe ? 1'b1 : ((|joy) ? 1'b0 : r_mouse_active);

    // An STR edge only advances the sequence if the port was already in mouse
    // mode and is staying there; leaving mouse mode takes precedence.
    assign w_edge       = stra ^ r_stra_q;
    assign w_adv        = w_edge && r_mouse_active && w_next_active;
    assign w_snap       = w_adv && (r_nib_state == NIB_XH);
    assign w_tmo_expire = r_mouse_active && w_next_active && !w_adv && (r_tmo == TMO_ONE);

    // Deltas in 10 bits so that negating -256 yields +256 before saturation.
    assign w_mx = {mouse_x[8], mouse_x};
    assign w_dx = INVERT_X ? -w_mx : w_mx;
    assign w_dy = {mouse_y[8], mouse_y};

    // At the capture edge the whole accumulator moves into the snapshot, so
    // acc - snap is zero and only a same-cycle delta remains.
    assign w_base_x = w_snap ? 10'sd0 : {{2{r_acc_x[7]}}, r_acc_x};
    assign w_base_y = w_snap ? 10'sd0 : {{2{r_acc_y[7]}}, r_acc_y};
    assign w_sum_x  = w_base_x + (mouse_strobe ? w_dx : 10'sd0);
    assign w_sum_y  = w_base_y + (mouse_strobe ? w_dy : 10'sd0);

    always_comb begin
        w_nibble = 4'hF;
        case (r_nib_state)
            NIB_XH:  w_nibble = r_acc_x[7:4];
            NIB_XL:  w_nibble = r_snap_x_lo;
            NIB_YH:  w_nibble = r_snap_y[7:4];
            NIB_YL:  w_nibble = r_snap_y[3:0];
            default: w_nibble = 4'hF;
        endcase
    end

    always_comb begin
        w_nib_next = r_nib_state;
        if (!w_next_active) begin
            w_nib_next = NIB_XH;
        end else if (w_adv) begin
            case (r_nib_state)
                NIB_XH:  w_nib_next = NIB_XL;
                NIB_XL:  w_nib_next = NIB_YH;
                NIB_YH:  w_nib_next = NIB_YL;
                default: w_nib_next = NIB_XH;
            endcase
        end else if (w_tmo_expire) begin
            w_nib_next = NIB_XH;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_nib_state <= NIB_XH;
        end else begin
            r_nib_state <= w_nib_next;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_mouse_active <= 1'b0;
            r_stra_q       <= stra;
            r_port         <= 6'h3F;
            r_acc_x        <= 8'h00;
            r_acc_y        <= 8'h00;
            r_snap_x_lo    <= 4'h0;
            r_snap_y       <= 8'h00;
            r_tmo          <= '0;
        end else begin
            r_stra_q       <= stra;
            r_mouse_active <= w_next_active;
            r_acc_x        <= sat8(w_sum_x);
            r_acc_y        <= sat8(w_sum_y);

            if (w_snap) begin
                r_snap_x_lo <= r_acc_x[3:0];
                r_snap_y    <= r_acc_y;
            end

            if (!w_next_active) begin
                r_port <= ~joy | {6{stra}};
                r_tmo  <= '0;
            end else begin
                if (mouse_strobe) begin
                    r_port[5:4] <= ~mouse_flags[1:0];
                end
                // Fresh entry into mouse mode shows released data pins until
                // the first nibble is served.
                if (!r_mouse_active) begin
                    r_port[3:0] <= 4'hF;
                end else if (w_adv) begin
                    r_port[3:0] <= w_nibble;
                end

                if (w_adv) begin
                    r_tmo <= TMO_LOAD;
                end else if (r_tmo != '0) begin
                    r_tmo <= r_tmo - TMO_ONE;
                end
            end
        end
    end

    assign port_o       = r_port;
    assign mouse_active = r_mouse_active;
    assign nibble_idx   = r_nib_state;

endmodule

// File: tb/tb_msx_mouse_port.sv
module tb_msx_mouse_port;

  localparam int TMO = 50;
  localparam bit INV = 1'b1;

  // ---------------- clock / reset ----------------
  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] mouse_x = '0;
  logic [8:0] mouse_y = '0;
  logic [7:0] mouse_flags = '0;
  logic       mouse_strobe = 1'b0;
  logic [5:0] joy = '0;
  logic       stra = 1'b0;
  logic [5:0] port_o;
  logic       mouse_active;
  logic [1:0] nibble_idx;

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  msx_mouse_port #(.TIMEOUT(TMO), .INVERT_X(INV)) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .mouse_x(mouse_x),
    .mouse_y(mouse_y),
    .mouse_flags(mouse_flags),
    .mouse_strobe(mouse_strobe),
    .joy(joy),
    .stra(stra),
    .port_o(port_o),
    .mouse_active(mouse_active),
    .nibble_idx(nibble_idx)
  );

  // ---------------- reference model state ----------------
  int         n_checks = 0;
  int         n_fail = 0;
  logic [5:0] exp_q[$];
  bit         mdl_mouse = 1'b0;
  int         acc_x = 0, acc_y = 0, snap_x = 0, snap_y = 0;
  int         mdl_idx = 0;
  int         last_edge = 0;
  logic [1:0] mdl_btn = 2'b11;
  logic [3:0] mdl_nib = 4'hF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Index falls back to 0 once TMO posedges have passed since the last edge.
  task automatic apply_timeout(input int done_cyc);
    if (done_cyc - last_edge >= TMO) mdl_idx = 0;
  endtask

  // ---------------- driver ----------------
  // One clock of stimulus; called and returns at a negedge.
  task automatic op_cycle(input bit s, input logic [8:0] x, input logic [8:0] y,
                          input logic [7:0] fl, input bit e, input logic [5:0] j);
    bit         was_mouse, adv;
    int         this_cyc, dx, dy;
    logic [7:0] bx, by;
    logic [3:0] nib;
    logic [5:0] exp_joy;
    this_cyc  = cyc + 1;
    was_mouse = mdl_mouse;
    mouse_strobe = s; mouse_x = x; mouse_y = y; mouse_flags = fl; joy = j;
    if (e) stra = ~stra;
    if (s) mdl_mouse = 1'b1;
    else if (j != 6'd0) mdl_mouse = 1'b0;
    adv = e && was_mouse && mdl_mouse;
    if (!was_mouse && mdl_mouse) mdl_nib = 4'hF;
    if (s) mdl_btn = ~fl[1:0];
    dx = $signed(x);
    if (INV) dx = -dx;
    dy = $signed(y);
    if (adv) begin
      apply_timeout(this_cyc - 1);
      if (mdl_idx == 0) begin
        snap_x = acc_x; snap_y = acc_y; acc_x = 0; acc_y = 0;
      end
      bx = snap_x[7:0];
      by = snap_y[7:0];
      case (mdl_idx)
        0: nib = bx[7:4];
        1: nib = bx[3:0];
        2: nib = by[7:4];
        default: nib = by[3:0];
      endcase
      exp_q.push_back({mdl_btn, nib});
      mdl_nib = nib;
      mdl_idx = (mdl_idx + 1) % 4;
      last_edge = this_cyc;
    end
    if (s) begin
      acc_x = sat(acc_x + dx);
      acc_y = sat(acc_y + dy);
    end
    if (!mdl_mouse) mdl_idx = 0;
    exp_joy = ~j | {6{stra}};
    @(negedge clk_sys);
    mouse_strobe = 1'b0; joy = '0;
    if (mdl_mouse) apply_timeout(cyc);
    check("mouse_active", mouse_active, mdl_mouse);
    check("nibble_idx", nibble_idx, mdl_idx);
    if (!mdl_mouse) check("joy_port", port_o, exp_joy);
    else if (!adv) check("mouse_port", port_o, {mdl_btn, mdl_nib});
  endtask

  task automatic strobe(input logic [8:0] x, input logic [8:0] y, input logic [7:0] fl);
    op_cycle(1'b1, x, y, fl, 1'b0, 6'd0);
  endtask

  task automatic edge_n(input int n);
    for (int k = 0; k < n; k++) op_cycle(1'b0, 9'd0, 9'd0, 8'd0, 1'b1, 6'd0);
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) op_cycle(1'b0, 9'd0, 9'd0, 8'd0, 1'b0, 6'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; mouse_strobe = 1'b0; joy = '0;
    mdl_mouse = 1'b0; acc_x = 0; acc_y = 0; snap_x = 0; snap_y = 0;
    mdl_idx = 0; mdl_nib = 4'hF; mdl_btn = 2'b11;
    @(negedge clk_sys);
    check("reset_port", port_o, 6'h3F);
    check("reset_active", mouse_active, 1'b0);
    check("reset_idx", nibble_idx, 2'd0);
    reset = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic mon_stra = 1'b0;
  always @(posedge clk_sys) begin
    bit e;
    logic [5:0] exp;
    e = (stra != mon_stra) && !reset && mdl_mouse;
    mon_stra = stra;
    if (e) begin
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL nibble_underflow: got 0x%0h with no expected entry", port_o);
      end else begin
        exp = exp_q.pop_front();
        check("nibble", port_o, exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    repeat (3) @(negedge clk_sys);
    do_reset();

    // +5/+3 -> F,B,0,3 then wrap
    strobe(9'd5, 9'd3, 8'd0);
    edge_n(4);

    // saturation: 3 x (-100) inverted -> +127 -> 7,F,0,0 then 0,0,0,0
    do_reset();
    for (int k = 0; k < 3; k++) strobe(9'(-100), 9'd0, 8'd0);
    edge_n(8);

    // capture edge with same-cycle strobe: acc_x=-4, +2 -> F,C then F,E
    do_reset();
    strobe(9'd4, 9'd0, 8'd0);
    op_cycle(1'b1, 9'd2, 9'd0, 8'd0, 1'b1, 6'd0);
    edge_n(3);
    edge_n(4);

    // -256 negates to +256 -> saturates +127; y=-256 -> -128
    do_reset();
    strobe(9'h100, 9'h100, 8'd0);
    edge_n(4);

    // timeout: 2 edges, then idle across the boundary
    do_reset();
    strobe(9'd7, 9'd9, 8'd0);
    edge_n(2);
    strobe(9'h30, 9'd1, 8'd0);
    idle_n(TMO + 1);
    edge_n(4);

    // joystick takeover and STR gating
    do_reset();
    strobe(9'd1, 9'd1, 8'd0);
    op_cycle(1'b0, 9'd0, 9'd0, 8'd0, stra, 6'b000100);
    op_cycle(1'b0, 9'd0, 9'd0, 8'd0, 1'b1, 6'b000100);
    idle_n(1);
    edge_n(2);
    // strobe beats joystick in the same cycle
    op_cycle(1'b1, 9'd3, 9'd0, 8'd0, 1'b0, 6'b110000);
    op_cycle(1'b1, 9'd0, 9'd0, 8'd2, 1'b0, 6'b000001);

    // buttons and reset mid-sequence
    do_reset();
    strobe(9'd8, 9'd8, 8'h01);
    edge_n(2);
    do_reset();
    idle_n(2);

    // randomized traffic
    strobe(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30)
        strobe(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)));
      else if (r < 60)
        edge_n(1);
      else if (r < 72)
        op_cycle(1'b1, 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
                 8'($urandom_range(0, 255)), mdl_mouse, 6'd0);
      else if (r < 80)
        op_cycle(1'b0, 9'd0, 9'd0, 8'd0, 1'($urandom_range(0, 1)), 6'($urandom_range(1, 63)));
      else if (r < 88)
        idle_n($urandom_range(1, TMO + 10));
      else if (r < 90)
        do_reset();
      else
        idle_n(1);
    end

    idle_n(3);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
